// File: rtl/icache_resp.sv
// icache_resp: fetch-side responder; direct-mapped cache of 4-word lines (ICACHE_EN) over an AXI read port.
// Latency: hit 1 cycle, refill >= 7, uncached >= 4; icache_stall backpressures the PC stage until the word is presented.
module icache_resp #(
    parameter int         INDEX_W = 7,
    parameter logic [3:0] AXI_ID  = 4'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_sram_en,
    input  logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_rdata,
    output logic        icache_ask,
    output logic        icache_stall,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);
    localparam logic [2:0] LOOKUP  = 3'd0;
    localparam logic [2:0] MISS_AR = 3'd1;
    localparam logic [2:0] REFILL  = 3'd2;
    localparam logic [2:0] UC_AR   = 3'd3;
    localparam logic [2:0] UC_R    = 3'd4;
    localparam logic [2:0] RESP    = 3'd5;

    logic [2:0]  state_q, state_d;
    logic        req_vld_q, req_vld_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] last_q, last_d;
    logic [31:0] lbuf_q [4];
    logic [31:0] lbuf_d [4];
    logic [1:0]  beat_q, beat_d;

    logic [31:0] paddr;
    logic [1:0]  off;
    logic        hit;
    logic        uncached;
    logic [31:0] hit_word;

    assign paddr = {3'b000, req_addr_q[28:0]};
    assign off   = req_addr_q[3:2];

`ifdef ICACHE_EN
    localparam int TAG_W = 28 - INDEX_W;
    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [31:0]        data_q [LINES][4];
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               fill_we;

    assign idx      = paddr[4+INDEX_W-1:4];
    assign tag      = paddr[31:4+INDEX_W];
    assign uncached = (req_addr_q[31:29] == 3'b101);
    // Arrays are read combinationally from the registered request, so a fill in RESP is visible to the next lookup.
    assign hit      = valid_q[idx] & (tag_q[idx] == tag) & ~uncached;
    assign hit_word = data_q[idx][off];
    assign fill_we  = (state_q == RESP) & ~uncached;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (fill_we) begin
            valid_q[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[idx] <= tag;
            for (int w = 0; w < 4; w++) begin
                data_q[idx][w] <= lbuf_q[w];
            end
        end
    end
`else
    localparam int unused_index_w = INDEX_W;
    logic unused_bits;
    assign unused_bits = ^{req_addr_q[31:29], rlast};
    assign uncached    = 1'b1;
    assign hit         = 1'b0;
    assign hit_word    = '0;
`endif

    always_comb begin
        icache_stall = 1'b0;
        case (state_q)
            MISS_AR, REFILL, UC_AR, UC_R: icache_stall = 1'b1;
            LOOKUP:                       icache_stall = req_vld_q & ~hit;
            default:                      icache_stall = 1'b0;
        endcase
    end

    assign icache_ask = inst_sram_en & ((state_q == LOOKUP) | (state_q == RESP)) & ~icache_stall;

    assign arid    = AXI_ID;
    assign arsize  = 3'd2;
    assign arburst = 2'b01;
    assign arvalid = (state_q == MISS_AR) | (state_q == UC_AR);
    assign araddr  = (state_q == MISS_AR) ? {paddr[31:4], 4'b0000} :
                     (state_q == UC_AR)   ? paddr : 32'd0;
    assign arlen   = (state_q == MISS_AR) ? 8'd3 : 8'd0;
    assign rready  = (state_q == REFILL) | (state_q == UC_R);

    assign inst_sram_rdata = (state_q == RESP)                     ? lbuf_q[off] :
                             ((state_q == LOOKUP) & req_vld_q & hit) ? hit_word :
                             last_q;

    always_comb begin
        state_d    = state_q;
        req_vld_d  = req_vld_q;
        req_addr_d = req_addr_q;
        lbuf_d     = lbuf_q;
        beat_d     = beat_q;
        last_d     = inst_sram_rdata;
        case (state_q)
            LOOKUP: begin
                if (req_vld_q & ~hit) begin
                    state_d = uncached ? UC_AR : MISS_AR;
                end
            end
            MISS_AR: begin
                beat_d = 2'd0;
                if (arready) state_d = REFILL;
            end
            REFILL: begin
                if (rvalid) begin
                    lbuf_d[beat_q] = rdata;
                    beat_d         = beat_q + 2'd1;
                    if (rlast) state_d = RESP;
                end
            end
            UC_AR: begin
                if (arready) state_d = UC_R;
            end
            UC_R: begin
                if (rvalid) begin
                    lbuf_d[off] = rdata;
                    state_d     = RESP;
                end
            end
            RESP:    state_d = LOOKUP;
            default: state_d = LOOKUP;
        endcase
        // A request is consumed by the state that sees it; a fresh one may arrive in LOOKUP or RESP.
        if (icache_ask) begin
            req_vld_d  = 1'b1;
            req_addr_d = inst_sram_addr;
        end else if ((state_q == LOOKUP) | (state_q == RESP)) begin
            req_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOOKUP;
            req_vld_q  <= 1'b0;
            req_addr_q <= '0;
            last_q     <= '0;
            lbuf_q     <= '{default: '0};
            beat_q     <= 2'd0;
        end else begin
            state_q    <= state_d;
            req_vld_q  <= req_vld_d;
            req_addr_q <= req_addr_d;
            last_q     <= last_d;
            lbuf_q     <= lbuf_d;
            beat_q     <= beat_d;
        end
    end
endmodule

// File: tb/tb_icache_resp.sv
// Bench for icache_resp: random fetch stream against a reference of the cache contents and a random-latency AXI slave.
module tb_icache_resp;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_sram_en = 1'b0;
    logic [31:0] inst_sram_addr = '0;
    logic [31:0] inst_sram_rdata;
    logic        icache_ask, icache_stall;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic        rlast = 1'b0;
    logic        rvalid = 1'b0;
    logic        rready;

    icache_resp dut (
        .clk(clk), .rst_n(rst_n),
        .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr), .inst_sram_rdata(inst_sram_rdata),
        .icache_ask(icache_ask), .icache_stall(icache_stall),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; bit hit; } exp_t;
    typedef struct packed { logic [31:0] addr; logic [7:0] len; } ar_t;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t exp_q[$];
    ar_t  exp_ar_q[$];
    int unsigned line_tag[int unsigned];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] pa);
        return (pa * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Reference: every fetch returns memory at the physical word; the cache only decides whether a read burst happens.
    function automatic void predict(input logic [31:0] va);
        logic [31:0] pa;
        exp_t e;
`ifdef ICACHE_EN
        int unsigned idx, tg;
`endif
        pa     = {3'b000, va[28:0]};
        e.data = memf(pa);
        e.hit  = 1'b0;
`ifdef ICACHE_EN
        idx = (pa >> 4) % 128;
        tg  = pa >> 11;
        if (va[31:29] == 3'b101) begin
            exp_ar_q.push_back('{addr: pa, len: 8'd0});
        end else if (line_tag.exists(idx) && line_tag[idx] == tg) begin
            e.hit = 1'b1;
        end else begin
            exp_ar_q.push_back('{addr: pa & ~32'hF, len: 8'd3});
            line_tag[idx] = tg;
        end
`else
        exp_ar_q.push_back('{addr: pa, len: 8'd0});
`endif
        exp_q.push_back(e);
    endfunction

    // Response monitor
    bit          pend = 1'b0;
    int          wait_cyc = 0;
    logic [31:0] last_rd = '0;
    exp_t        cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_ar_q.delete();
            line_tag.delete();
            pend    = 1'b0;
            last_rd = '0;
        end else begin
            if (pend && !icache_stall) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", 32'd1, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("resp_data", inst_sram_rdata, cur.data);
                    chk("resp_hit_latency", {31'b0, wait_cyc == 0}, {31'b0, cur.hit});
                    last_rd = cur.data;
                end
                pend = 1'b0;
            end else begin
                chk("hold_rdata", inst_sram_rdata, last_rd);
                if (pend) begin
                    wait_cyc++;
                    if (wait_cyc > 400) begin
                        chk("resp_timeout", 32'd1, 32'd0);
                        pend = 1'b0;
                    end
                end
            end
            if (icache_ask) begin
                predict(inst_sram_addr);
                pend     = 1'b1;
                wait_cyc = 0;
            end
        end
    end

    // AXI read slave with random ready/valid timing
    ar_t         bursts[$];
    ar_t         got;
    int          beat = 0;
    int          ar_count = 0;
    int          ar_hold = 0;
    logic        prev_arv = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [7:0]  prev_len = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
            bursts.delete();
            beat = 0; prev_arv = 1'b0;
        end else begin
            rvalid = 1'b0;
            rlast  = 1'b0;
            if (bursts.size() > 0 && $urandom_range(0, 3) != 0) begin
                rvalid = 1'b1;
                rdata  = memf(bursts[0].addr + 32'(4 * beat));
                rlast  = (beat == int'(bursts[0].len));
                if (rready) begin
                    beat++;
                    if (rlast) begin
                        void'(bursts.pop_front());
                        beat = 0;
                    end
                end
            end
            if (ar_hold > 0 && arvalid) begin
                arready = 1'b0;
                ar_hold--;
                chk("hold_stall", {31'b0, icache_stall}, 32'd1);
                if (inst_sram_en) chk("hold_ask", {31'b0, icache_ask}, 32'd0);
            end else begin
                arready = arvalid && ($urandom_range(0, 2) != 0);
            end
            if (prev_arv) begin
                chk("ar_stable_vld", {31'b0, arvalid}, 32'd1);
                chk("ar_stable_addr", araddr, prev_addr);
                chk("ar_stable_len", {24'b0, arlen}, {24'b0, prev_len});
            end
            if (arvalid && arready) begin
                if (exp_ar_q.size() == 0) begin
                    chk("ar_unexpected", araddr, 32'hFFFF_FFFF);
                end else begin
                    got = exp_ar_q.pop_front();
                    chk("ar_addr", araddr, got.addr);
                    chk("ar_len", {24'b0, arlen}, {24'b0, got.len});
                end
                chk("ar_const", {23'b0, arid, arsize, arburst}, {23'b0, 4'h0, 3'd2, 2'b01});
                bursts.push_back('{addr: araddr, len: arlen});
                ar_count++;
                prev_arv = 1'b0;
            end else begin
                prev_arv  = arvalid;
                prev_addr = araddr;
                prev_len  = arlen;
            end
        end
    end

    task automatic fetch(input logic [31:0] a);
        int k;
        inst_sram_en   = 1'b1;
        inst_sram_addr = a;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!icache_ask && k < 500);
        if (!icache_ask) chk("fetch_accept", a, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        inst_sram_en = 1'b0;
    endtask

    task automatic idle(input int n);
        inst_sram_en = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_rdata"}, inst_sram_rdata, 32'd0);
        chk({tag, "_ask"}, {31'b0, icache_ask}, 32'd0);
        chk({tag, "_stall"}, {31'b0, icache_stall}, 32'd0);
        chk({tag, "_arvalid"}, {31'b0, arvalid}, 32'd0);
        chk({tag, "_rready"}, {31'b0, rready}, 32'd0);
        chk({tag, "_araddr"}, araddr, 32'd0);
        chk({tag, "_arlen"}, {24'b0, arlen}, 32'd0);
    endtask

    initial begin
        logic [31:0] va;
        int cnt0;
        bit seen;
        repeat (3) @(posedge clk);
        #3;
        check_reset("por");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        fetch(32'hBFC0_0000);
        fetch(32'h8000_0008);
        fetch(32'h8000_000C);
        fetch(32'h8000_0800);
        fetch(32'h8000_0000);
        idle(2);

        ar_hold = 5;
        fetch(32'h8000_1000);
        fetch(32'h8000_1004);
        idle(3);

        // Reset in the middle of a read: after two refill beats, or once the uncached read address is taken.
        cnt0 = ar_count;
        fetch(32'h8000_0008);
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(posedge clk);
            #2;
`ifdef ICACHE_EN
            seen = (beat == 2);
`else
            seen = (ar_count > cnt0);
`endif
        end
        if (!seen) chk("midburst_reached", 32'd0, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        fetch(32'h8000_0008);
        idle(2);

        for (int i = 0; i < 300; i++) begin
            va = (($urandom_range(0, 4) == 0) ? 32'hA000_0000 : 32'h8000_0000)
               | (32'($urandom_range(0, 2)) << 11)
               | (32'($urandom_range(0, 3)) << 4)
               | (32'($urandom_range(0, 3)) << 2);
            fetch(va);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(40);
        chk("drain_resp", 32'(exp_q.size()), 32'd0);
        chk("drain_ar", 32'(exp_ar_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end
endmodule
